jstk_spi_responder: RTL and testbench

//   SPI slave (SPI mode 0) that plays the PmodJSTK role: answers the 5-byte joystick

---
 rtl/jstk_spi_responder.sv | 128 ++++++++++++
 tb/tb_jstk_spi_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/jstk_spi_responder.sv
// jstk_spi_responder: SPI mode-0 slave emulating the PmodJSTK, oversampled on CLK.
// Reports X/Y/buttons on MISO and latches the LED command from MOSI byte 0.
module jstk_spi_responder #(
   parameter int NUM_BYTES   = 5,
   parameter int SYNC_STAGES = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       SCLK,
   input  logic       SS,
   input  logic       MOSI,
   output logic       MISO,
   input  logic [9:0] X_POS,
   input  logic [9:0] Y_POS,
   input  logic [2:0] BTNS,
   output logic [1:0] LED_CMD,
   output logic       BUSY,
   output logic       FRAME_DONE,
   output logic       FRAME_ERR
);
   localparam int NB = 8 * NUM_BYTES;
   localparam int CW = $clog2(NB + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_q, ss_q, mosi_q;
   logic                   sclk_h_q, ss_h_q;
   logic [NB-1:0]          tx_q, tx_d, rx_q, rx_d, load;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [1:0]             led_q, led_d;
   logic                   done_q, done_d, err_q, err_d;
   logic                   sclk_s, ss_s, mosi_s;
   logic                   sclk_rise, sclk_fall, ss_rise, ss_fall, full;

   assign sclk_s    = sclk_q[SYNC_STAGES-1];
   assign ss_s      = ss_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_h_q;
   assign sclk_fall = ~sclk_s & sclk_h_q;
   assign ss_rise   = ss_s & ~ss_h_q;
   assign ss_fall   = ~ss_s & ss_h_q;
   assign full      = cnt_q == CW'(NB);
   // Frame image is left-aligned so byte 0 leaves first; any extra bytes read as zero.
   assign load = NB'({X_POS[7:0], 6'b0, X_POS[9:8], Y_POS[7:0], 6'b0, Y_POS[9:8], 5'b0, BTNS})
                 << (NB - 40);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sclk_q   <= '0;
         ss_q     <= '1;
         mosi_q   <= '0;
         sclk_h_q <= 1'b0;
         ss_h_q   <= 1'b1;
      end else begin
         sclk_q   <= {sclk_q[SYNC_STAGES-2:0], SCLK};
         ss_q     <= {ss_q[SYNC_STAGES-2:0], SS};
         mosi_q   <= {mosi_q[SYNC_STAGES-2:0], MOSI};
         sclk_h_q <= sclk_s;
         ss_h_q   <= ss_s;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE && ss_fall) state_d = SHIFT;
      if (state_q == SHIFT && ss_rise) state_d = IDLE;
   end

   always_comb begin
      BUSY = state_q == SHIFT;
      MISO = BUSY && !ss_s && !full && tx_q[NB-1];
   end

   // SS strobes are handled before SCLK strobes, so a coincident SCLK edge is dropped.
   always_comb begin
      tx_d   = tx_q;
      rx_d   = rx_q;
      cnt_d  = cnt_q;
      led_d  = led_q;
      done_d = 1'b0;
      err_d  = 1'b0;
      if (state_q == IDLE) begin
         if (ss_fall) begin
            tx_d  = load;
            rx_d  = '0;
            cnt_d = '0;
         end
      end else if (ss_rise) begin
         done_d = full;
         err_d  = !full;
         led_d  = (full && rx_q[NB-1]) ? rx_q[NB-7 -: 2] : led_q;
      end else begin
         if (sclk_rise && !full) begin
            rx_d  = {rx_q[NB-2:0], mosi_s};
            cnt_d = cnt_q + CW'(1);
         end
         if (sclk_fall && cnt_q != '0 && !full) tx_d = tx_q << 1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         tx_q   <= '0;
         rx_q   <= '0;
         cnt_q  <= '0;
         led_q  <= 2'b00;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         tx_q   <= tx_d;
         rx_q   <= rx_d;
         cnt_q  <= cnt_d;
         led_q  <= led_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign LED_CMD    = led_q;
   assign FRAME_DONE = done_q;
   assign FRAME_ERR  = err_q;
endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb_jstk_spi_responder: drives SPI master frames into the responder and checks
// MISO data, LED command and frame pulses against hand-computed vectors.
module tb_jstk_spi_responder;
   logic       CLK = 1'b0, RESET = 1'b0, SCLK = 1'b0, SS = 1'b1, MOSI = 1'b0;
   logic [9:0] X_POS = '0, Y_POS = '0;
   logic [2:0] BTNS = '0;
   logic       MISO, BUSY, FRAME_DONE, FRAME_ERR;
   logic [1:0] LED_CMD;
   int         n_chk = 0, n_fail = 0, dcnt = 0, ecnt = 0;

   localparam int HALF = 16;

   typedef struct {
      logic [9:0]  x, y, x2;
      logic [2:0]  b;
      logic [39:0] mosi;
      int          nbits;
      int          chg;
      logic [39:0] exp_miso;
      logic [1:0]  exp_led;
      int          exp_done, exp_err;
   } vec_t;

   jstk_spi_responder dut (
      .CLK(CLK), .RESET(RESET), .SCLK(SCLK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
      .X_POS(X_POS), .Y_POS(Y_POS), .BTNS(BTNS), .LED_CMD(LED_CMD), .BUSY(BUSY),
      .FRAME_DONE(FRAME_DONE), .FRAME_ERR(FRAME_ERR)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (FRAME_DONE) dcnt++;
      if (FRAME_ERR) ecnt++;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_frame(input vec_t t, output logic [47:0] cap, output int dd,
                            output int de, output logic busy_mid);
      int d0, e0;
      d0 = dcnt;
      e0 = ecnt;
      cap = '0;
      busy_mid = 1'b0;
      X_POS = t.x;
      Y_POS = t.y;
      BTNS = t.b;
      cyc(4);
      SS = 1'b0;
      MOSI = t.mosi[39];
      cyc(HALF);
      for (int i = 0; i < t.nbits; i++) begin
         cap[47-i] = MISO;
         SCLK = 1'b1;
         cyc(HALF);
         if (i == 4) busy_mid = BUSY;
         SCLK = 1'b0;
         if (t.chg != 0 && i == t.chg - 1) X_POS = t.x2;
         MOSI = (i + 1 < 40) ? t.mosi[38-i] : 1'b0;
         cyc(HALF);
      end
      SS = 1'b1;
      cyc(10);
      dd = dcnt - d0;
      de = ecnt - e0;
   endtask

   vec_t        v[8];
   vec_t        r;
   logic [47:0] cap, m;
   int          dd, de;
   logic        bm;

   initial begin
      v[0] = '{10'h2A5, 10'h13C, 10'h2A5, 3'b101, 40'h83_00000000, 40, 0, 40'hA5023C0105, 2'b11, 1, 0};
      v[1] = '{10'h2A5, 10'h13C, 10'h2A5, 3'b101, 40'h03_00000000, 40, 0, 40'hA5023C0105, 2'b11, 1, 0};
      v[2] = '{10'h2A5, 10'h13C, 10'h2A5, 3'b101, 40'h81_00000000, 12, 0, 40'hA5023C0105, 2'b11, 0, 1};
      v[3] = '{10'h2A5, 10'h13C, 10'h2A5, 3'b101, 40'h00_00000000, 40, 0, 40'hA5023C0105, 2'b11, 1, 0};
      v[4] = '{10'h2A5, 10'h13C, 10'h3FF, 3'b101, 40'h00_00000000, 40, 8, 40'hA5023C0105, 2'b11, 1, 0};
      v[5] = '{10'h3FF, 10'h13C, 10'h3FF, 3'b101, 40'h81_00000000, 40, 0, 40'hFF033C0105, 2'b01, 1, 0};
      v[6] = '{10'h000, 10'h3FF, 10'h000, 3'b010, 40'h00_FFFFFFFF, 44, 0, 40'h0000FF0302, 2'b01, 1, 0};
      v[7] = '{10'h155, 10'h0AA, 10'h155, 3'b111, 40'h82_00000000, 40, 0, 40'h5501AA0007, 2'b10, 1, 0};

      // reset held with SS low and SCLK toggling
      SS = 1'b0;
      for (int i = 0; i < 6; i++) begin
         SCLK = ~SCLK;
         cyc(HALF);
         chk("rst_miso", 48'(MISO), 48'd0);
      end
      chk("rst_led", 48'(LED_CMD), 48'd0);
      chk("rst_busy", 48'(BUSY), 48'd0);
      SS = 1'b1;
      SCLK = 1'b0;
      cyc(4);
      RESET = 1'b1;
      cyc(10);
      chk("rst_pulses", 48'(dcnt + ecnt), 48'd0);
      chk("idle_busy", 48'(BUSY), 48'd0);

      for (int k = 0; k < 8; k++) begin
         run_frame(v[k], cap, dd, de, bm);
         m = ~48'h0 << (48 - v[k].nbits);
         chk($sformatf("v%0d_miso", k), cap & m, {v[k].exp_miso, 8'h00} & m);
         chk($sformatf("v%0d_led", k), 48'(LED_CMD), 48'(v[k].exp_led));
         chk($sformatf("v%0d_done", k), 48'(dd), 48'(v[k].exp_done));
         chk($sformatf("v%0d_err", k), 48'(de), 48'(v[k].exp_err));
         chk($sformatf("v%0d_busy_mid", k), 48'(bm), 48'd1);
         chk($sformatf("v%0d_busy_end", k), 48'(BUSY), 48'd0);
      end

      // reset asserted during byte 2
      X_POS = 10'h2A5;
      Y_POS = 10'h13C;
      BTNS = 3'b101;
      cyc(4);
      SS = 1'b0;
      cyc(HALF);
      for (int i = 0; i < 20; i++) begin
         SCLK = 1'b1;
         cyc(HALF);
         SCLK = 1'b0;
         cyc(HALF);
      end
      chk("mid_busy_before", 48'(BUSY), 48'd1);
      dd = dcnt;
      de = ecnt;
      RESET = 1'b0;
      #1;
      chk("mid_rst_miso", 48'(MISO), 48'd0);
      chk("mid_rst_busy", 48'(BUSY), 48'd0);
      chk("mid_rst_led", 48'(LED_CMD), 48'd0);
      SS = 1'b1;
      cyc(10);
      RESET = 1'b1;
      cyc(10);
      chk("mid_rst_pulses", 48'((dcnt - dd) + (ecnt - de)), 48'd0);
      chk("mid_rst_led_after", 48'(LED_CMD), 48'd0);

      r = '{10'h2A5, 10'h13C, 10'h2A5, 3'b101, 40'h81_00000000, 40, 0, 40'hA5023C0105, 2'b01, 1, 0};
      run_frame(r, cap, dd, de, bm);
      chk("post_rst_miso", cap, {r.exp_miso, 8'h00});
      chk("post_rst_led", 48'(LED_CMD), 48'(r.exp_led));
      chk("post_rst_done", 48'(dd), 48'd1);
      chk("post_rst_err", 48'(de), 48'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
